// File: rtl/switch_conditioner.sv
// Push-button front end: per-channel two-flop synchronizer, debounce counter and press/hold FSM.
// Build macro SWITCH_AUTO_REPEAT_EN adds auto-repeat press pulses while a channel is held.
module switch_conditioner #(
   parameter int g_NUM_SWITCHES   = 4,
   parameter int g_DEBOUNCE_LIMIT = 250000,
   parameter int g_HOLD_DELAY     = 75000000,
   parameter int g_REPEAT_DELAY   = 4166666
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset,
   input  logic [g_NUM_SWITCHES-1:0] i_Switches,
   output logic [g_NUM_SWITCHES-1:0] o_Switches,
   output logic [g_NUM_SWITCHES-1:0] o_Press,
   output logic [g_NUM_SWITCHES-1:0] o_Release,
   output logic [g_NUM_SWITCHES-1:0] o_Hold,
   output logic [g_NUM_SWITCHES-1:0] o_Held
);

   // state  | meaning
   // S_UP   | debounced level released, waiting for an accepted press
   // S_DOWN | pressed, hold counter running toward g_HOLD_DELAY
   // S_HELD | hold event issued, o_Held high until release
   typedef enum logic [1:0] {
      S_UP   = 2'b00,
      S_DOWN = 2'b01,
      S_HELD = 2'b10
   } state_t;

   localparam int                c_DB_W     = $clog2(g_DEBOUNCE_LIMIT) + 1;
   localparam logic [c_DB_W-1:0] c_DB_MAX   = c_DB_W'(g_DEBOUNCE_LIMIT - 1);
   localparam logic [31:0]       c_HOLD_MAX = 32'(g_HOLD_DELAY - 1);
   localparam logic [31:0]       c_REP_MAX  = 32'(g_REPEAT_DELAY - 1);

   genvar gi;
   generate
      for (gi = 0; gi < g_NUM_SWITCHES; gi++) begin : g_ch
         logic [1:0]        r_sync;
         logic              r_deb;
         logic [c_DB_W-1:0] r_db_cnt;
         state_t            r_state;
         state_t            w_next;
         logic [31:0]       r_hold_cnt;
         logic              r_press;
         logic              r_release;
         logic              r_hold;
         logic              w_accept;
         logic              w_rise;
         logic              w_fall;
         logic              w_hold_hit;
         logic              w_repeat;
         logic              w_press_d;
         logic              w_release_d;
         logic              w_hold_d;

         // Events are decoded from the same condition that updates r_deb, so they line up with o_Switches.
         assign w_accept   = (r_sync[1] != r_deb) && (r_db_cnt == c_DB_MAX);
         assign w_rise     = w_accept & r_sync[1];
         assign w_fall     = w_accept & ~r_sync[1];
         assign w_hold_hit = (r_hold_cnt == c_HOLD_MAX);

         always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
               r_sync   <= '0;
               r_deb    <= 1'b0;
               r_db_cnt <= '0;
            end else begin
               r_sync <= {r_sync[0], i_Switches[gi]};
               if (r_sync[1] == r_deb) begin
                  r_db_cnt <= '0;
               end else if (w_accept) begin
                  r_deb    <= r_sync[1];
                  r_db_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + c_DB_W'(1);
               end
            end
         end

         always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
               r_state    <= S_UP;
               r_hold_cnt <= '0;
               r_press    <= 1'b0;
               r_release  <= 1'b0;
               r_hold     <= 1'b0;
            end else begin
               r_state   <= w_next;
               r_press   <= w_press_d;
               r_release <= w_release_d;
               r_hold    <= w_hold_d;
               // Cleared while up, counts while down, frozen (saturated) while held.
               if (r_state == S_UP) begin
                  r_hold_cnt <= '0;
               end else if (r_state == S_DOWN) begin
                  r_hold_cnt <= r_hold_cnt + 32'd1;
               end
            end
         end

         always_comb begin
            w_next = S_UP;
            case (r_state)
               S_UP:    w_next = w_rise ? S_DOWN : S_UP;
               S_DOWN: begin
                  if (w_fall) begin
                     w_next = S_UP;
                  end else if (w_hold_hit) begin
                     w_next = S_HELD;
                  end else begin
                     w_next = S_DOWN;
                  end
               end
               S_HELD:  w_next = w_fall ? S_UP : S_HELD;
               default: w_next = S_UP;
            endcase
         end

         always_comb begin
            w_press_d   = 1'b0;
            w_release_d = 1'b0;
            w_hold_d    = 1'b0;
            case (r_state)
               S_UP:   w_press_d = w_rise;
               S_DOWN: begin
                  w_release_d = w_fall;
                  w_hold_d    = ~w_fall & w_hold_hit;
               end
               S_HELD: begin
                  w_release_d = w_fall;
                  w_press_d   = w_repeat;
               end
               default: ;
            endcase
         end

`ifdef SWITCH_AUTO_REPEAT_EN
         logic [31:0] r_rep_cnt;

         assign w_repeat = ~w_fall && (r_rep_cnt == c_REP_MAX);

         always_ff @(posedge i_Clk) begin
            if (i_Reset || (r_state != S_HELD) || w_fall || w_repeat) begin
               r_rep_cnt <= '0;
            end else begin
               r_rep_cnt <= r_rep_cnt + 32'd1;
            end
         end
`else
         logic w_unused_rep;

         assign w_repeat     = 1'b0;
         assign w_unused_rep = ^c_REP_MAX;
`endif

         assign o_Switches[gi] = r_deb;
         assign o_Press[gi]    = r_press;
         assign o_Release[gi]  = r_release;
         assign o_Hold[gi]     = r_hold;
         assign o_Held[gi]     = (r_state == S_HELD);
      end
   endgenerate

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
Front end for the board push-buttons. Synchronizes and debounces each raw switch pin and produces clean levels plus one-cycle press, release and long-hold events. Drives the switch inputs of the mode state machine, which consumes clean falling edges and a 3 s hold on switch 4.

Parameters:
g_NUM_SWITCHES, 4, number of independent switch channels
g_DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); minimum 1
g_HOLD_DELAY, 75000000, cycles a debounced press must last before the hold event fires (3 s at 25 MHz); minimum 1
g_REPEAT_DELAY, 4166666, cycles between auto-repeat press pulses while held (only used with the optional feature)

Ports:
i_Clk  in  1  system clock, 25 MHz
i_Reset  in  1  synchronous reset, active-high
i_Switches  in  g_NUM_SWITCHES  raw asynchronous pins, 1 = pressed
o_Switches  out  g_NUM_SWITCHES  debounced level per channel
o_Press  out  g_NUM_SWITCHES  one-cycle pulse on accepted 0->1
o_Release  out  g_NUM_SWITCHES  one-cycle pulse on accepted 1->0
o_Hold  out  g_NUM_SWITCHES  one-cycle pulse when a press reaches g_HOLD_DELAY
o_Held  out  g_NUM_SWITCHES  level, high from the hold pulse until release

Behaviour:
- All channels are identical and independent. There is no interaction between channels; simultaneous events on several channels are all reported in the same cycle.
- Reset: synchronous, checked at every posedge i_Clk, and has priority over all other logic. It clears sync flops, debounce and hold counters, and all outputs to 0, and puts every channel FSM in UP. Reset mid-press drops any in-progress count. A switch still down after reset re-qualifies as a fresh press.
- Synchronizer: two flops per channel, reset to 0. Debounce logic sees only the second stage.
- Debounce counter (width = clog2(g_DEBOUNCE_LIMIT)+1):
  - sync == debounced: counter <= 0.
  - sync != debounced and counter == g_DEBOUNCE_LIMIT-1: debounced <= sync, counter <= 0.
  - Otherwise: counter + 1.
- Latency: a pin change first sampled at edge 1 appears on o_Switches after edge g_DEBOUNCE_LIMIT+2. Any bounce back to the old level before then restarts the count, and no event is produced.
- Per-channel FSM. States: UP, DOWN, HELD. Events are registered and change in the same cycle as o_Switches.
  - UP -> DOWN when debounced rises. o_Press = 1 for that cycle; hold counter (32-bit) <= 0.
  - DOWN: hold counter increments each cycle while down.
  - DOWN -> HELD when the hold counter == g_HOLD_DELAY-1. o_Hold = 1 for one cycle; o_Held <= 1. The hold pulse therefore lands g_HOLD_DELAY cycles after o_Press.
  - DOWN -> UP on debounced fall: o_Release pulse; no hold event.
  - HELD -> UP on debounced fall: o_Release pulse and o_Held <= 0 in the same cycle.
  - The hold counter saturates in HELD and never wraps. o_Hold fires at most once per press.
- Illegal or unused FSM encoding returns to UP with outputs 0.
- Press, release and hold pulses are never asserted for more than one consecutive cycle.

Optional Feature:
SWITCH_AUTO_REPEAT_EN
- Defined: in HELD, a repeat counter runs from 0 at HELD entry. o_Press pulses for one cycle every g_REPEAT_DELAY cycles: the first pulse comes g_REPEAT_DELAY cycles after o_Hold, and repeats continue until release. Release clears the repeat counter, and no repeat pulse fires in the release cycle.
- Not defined: the repeat counter and logic are absent. o_Press pulses only on the UP->DOWN transition.

Test Plan:
1. Params LIMIT=4, HOLD=20, REPEAT=5. Reset, then set i_Switches=4'b0001 and hold it. o_Switches[0] rises after edge 6, with o_Press[0] = 1 for exactly that cycle. All other outputs stay 0.
2. Bounce: channel 1 high for 3 cycles, low for 1, then high steadily. Exactly one o_Press[1] pulse, 6 cycles after the final rise. Releasing with 2-cycle glitches produces exactly one o_Release[1].
3. Hold: keep channel 3 pressed. o_Hold[3] pulses 20 cycles after o_Press[3] and o_Held[3] = 1. On release, o_Release[3] and o_Held[3]=0 occur in the same cycle, with no second o_Hold.
4. Short press on channel 2 lasting 10 debounced cycles (less than HOLD): o_Press[2], then o_Release[2], with o_Hold[2] never asserted. Channels 0 and 2 pressed in the same cycle: both o_Press bits assert together.
5. Reset mid-hold: assert i_Reset for 1 cycle at hold count 15 while channel 0 stays pressed. All outputs go 0 the next cycle, then a new o_Press[0] fires 6 cycles after reset deasserts.
6. With SWITCH_AUTO_REPEAT_EN: hold channel 0. o_Hold at t, then o_Press at t+5, t+10 and t+15 until release, with none in the release cycle. Without the macro, no o_Press pulses occur after o_Hold.
